// File: rtl/mcp3_ohc_mon.sv
// Registered one-hot checker/monitor with a sticky first-error record.
// Optional saturating error counter enabled by defining MCP3_OHC_ERR_COUNT_EN.
module mcp3_ohc_mon #(
    parameter int WIDTH     = 8,
    parameter int ZERO_OK   = 0,
    parameter int CNT_WIDTH = 8,
    localparam int ENC_W    = $clog2(WIDTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 check_valid,
    input  logic [WIDTH-1:0]     one_hot_vector,
    input  logic                 err_clear,
    output logic                 one_hot_error,
    output logic                 err_zero,
    output logic                 err_multi,
    output logic                 enc_valid,
    output logic [ENC_W-1:0]     enc_index,
    output logic                 sticky_error,
    output logic [WIDTH-1:0]     first_err_vector,
    output logic [1:0]           first_err_type
`ifdef MCP3_OHC_ERR_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] err_count
`endif
);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CAPTURED = 1'b1
    } state_e;

    generate
        if (WIDTH < 2 || WIDTH > 64 || CNT_WIDTH < 1) begin : g_bad_params
            $error("mcp3_ohc_mon: parameter out of range");
        end
    endgenerate

    logic             zero_hit;
    logic             multi_hit;
    logic             one_hit;
    logic [ENC_W-1:0] idx_or;

    logic             one_hot_error_q, one_hot_error_d;
    logic             err_zero_q, err_zero_d;
    logic             err_multi_q, err_multi_d;
    logic             enc_valid_q, enc_valid_d;
    logic [ENC_W-1:0] enc_index_q, enc_index_d;
    logic [WIDTH-1:0] sample_vec_q, sample_vec_d;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] first_err_vector_q, first_err_vector_d;
    logic [1:0]       first_err_type_q, first_err_type_d;

    // v & (v-1) clears the lowest set bit; anything left means two or more bits.
    always_comb begin
        zero_hit  = (one_hot_vector == '0) && (ZERO_OK == 0);
        multi_hit = |(one_hot_vector & (one_hot_vector - WIDTH'(1)));
        one_hit   = (one_hot_vector != '0) && !multi_hit;
        idx_or    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (one_hot_vector[i]) begin
                idx_or = idx_or | ENC_W'(i);
            end
        end
    end

    always_comb begin
        one_hot_error_d = 1'b0;
        err_zero_d      = 1'b0;
        err_multi_d     = 1'b0;
        enc_valid_d     = 1'b0;
        enc_index_d     = enc_index_q;
        sample_vec_d    = sample_vec_q;
        if (check_valid) begin
            one_hot_error_d = zero_hit | multi_hit;
            err_zero_d      = zero_hit;
            err_multi_d     = multi_hit;
            enc_valid_d     = one_hit;
            enc_index_d     = one_hit ? idx_or : '0;
            sample_vec_d    = one_hot_vector;
        end
    end

    // A clear coinciding with a new error re-arms and captures in one step.
    always_comb begin
        state_d            = state_q;
        first_err_vector_d = first_err_vector_q;
        first_err_type_d   = first_err_type_q;
        case (state_q)
            ST_IDLE: begin
                if (one_hot_error_q) begin
                    state_d            = ST_CAPTURED;
                    first_err_vector_d = sample_vec_q;
                    first_err_type_d   = {err_multi_q, err_zero_q};
                end
            end
            ST_CAPTURED: begin
                if (err_clear) begin
                    if (one_hot_error_q) begin
                        state_d            = ST_CAPTURED;
                        first_err_vector_d = sample_vec_q;
                        first_err_type_d   = {err_multi_q, err_zero_q};
                    end else begin
                        state_d            = ST_IDLE;
                        first_err_vector_d = '0;
                        first_err_type_d   = 2'b00;
                    end
                end
            end
            default: begin
                state_d            = ST_IDLE;
                first_err_vector_d = '0;
                first_err_type_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            one_hot_error_q    <= 1'b0;
            err_zero_q         <= 1'b0;
            err_multi_q        <= 1'b0;
            enc_valid_q        <= 1'b0;
            enc_index_q        <= '0;
            sample_vec_q       <= '0;
            state_q            <= ST_IDLE;
            first_err_vector_q <= '0;
            first_err_type_q   <= 2'b00;
        end else begin
            one_hot_error_q    <= one_hot_error_d;
            err_zero_q         <= err_zero_d;
            err_multi_q        <= err_multi_d;
            enc_valid_q        <= enc_valid_d;
            enc_index_q        <= enc_index_d;
            sample_vec_q       <= sample_vec_d;
            state_q            <= state_d;
            first_err_vector_q <= first_err_vector_d;
            first_err_type_q   <= first_err_type_d;
        end
    end

`ifdef MCP3_OHC_ERR_COUNT_EN
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_clear ? '0 : err_count_q;
        if (one_hot_error_q && (err_count_d != '1)) begin
            err_count_d = err_count_d + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

    assign one_hot_error    = one_hot_error_q;
    assign err_zero         = err_zero_q;
    assign err_multi        = err_multi_q;
    assign enc_valid        = enc_valid_q;
    assign enc_index        = enc_index_q;
    assign sticky_error     = (state_q == ST_CAPTURED);
    assign first_err_vector = first_err_vector_q;
    assign first_err_type   = first_err_type_q;

endmodule
